// File: rtl/systolic_ctrl_if.sv
// Job/feed/result handshake bundle between systolic_ctrl and its job source, array muxes and result consumer.
// master = job source/consumer side, slave = controller side.
interface systolic_ctrl_if #(
    parameter int N  = 4,
    parameter int KW = 8,
    parameter int RW = 2
);
    logic          start;
    logic [KW-1:0] k_len;
    logic          abort;
    logic          busy;
    logic          done;
    logic          start_err;
    logic          array_clr;
    logic          feed_en;
    logic [KW:0]   feed_t;
    logic [N-1:0]  lane_valid;
    logic          res_valid;
    logic          res_ready;
    logic [RW-1:0] res_row;

    modport master (
        output start, k_len, abort, res_ready,
        input  busy, done, start_err, array_clr, feed_en, feed_t, lane_valid, res_valid, res_row
    );

    modport slave (
        input  start, k_len, abort, res_ready,
        output busy, done, start_err, array_clr, feed_en, feed_t, lane_valid, res_valid, res_row
    );
endinterface

// File: rtl/systolic_ctrl.sv
// Output-stationary systolic array sequencer: clear, skewed feed of K+2N-2 cycles, then N result rows.
// Start-to-first-row latency K+2N cycles; result rows hold under res_ready=0, abort/reset return to IDLE.
module systolic_ctrl #(
    parameter int N  = 4,
    parameter int KW = 8,
    parameter int RW = 2
) (
    input  logic           clk,
    input  logic           rst,
    systolic_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_READ,
        S_DONE
    } state_t;

    localparam logic [KW:0]   TAIL     = (KW+1)'(2*N-3);
    localparam logic [RW-1:0] LAST_ROW = RW'(N-1);

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW:0]   feed_t_q, feed_t_d;
    logic [RW-1:0] res_row_q, res_row_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          start_err_q, start_err_d;
    logic          res_valid_q, res_valid_d;
    logic [KW:0]   feed_last;
    logic          feed_en;
    logic [N-1:0]  lane_valid;

    assign feed_last = {1'b0, k_q} + TAIL;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        feed_t_d    = '0;
        res_row_d   = '0;
        start_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.k_len != '0) begin
                        k_d     = bus.k_len;
                        state_d = S_CLEAR;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            S_CLEAR: state_d = S_FEED;
            S_FEED: begin
                if (feed_t_q == feed_last) begin
                    state_d = S_READ;
                end else begin
                    feed_t_d = feed_t_q + (KW+1)'(1);
                end
            end
            S_READ: begin
                // res_valid is always high in READ, so ready alone completes the handshake
                res_row_d = res_row_q;
                if (bus.res_ready) begin
                    if (res_row_q == LAST_ROW) begin
                        state_d   = S_DONE;
                        res_row_d = '0;
                    end else begin
                        res_row_d = res_row_q + RW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if ((state_q != S_IDLE) && bus.abort) begin
            state_d   = S_IDLE;
            feed_t_d  = '0;
            res_row_d = '0;
        end
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        res_valid_d = (state_d == S_READ);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            feed_t_q    <= '0;
            res_row_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            feed_t_q    <= feed_t_d;
            res_row_q   <= res_row_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            start_err_q <= start_err_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign feed_en = (state_q == S_FEED);

    // lane i carries element t-i; the short-circuit keeps t-i from being used when it would underflow
    always_comb begin
        lane_valid = '0;
        for (int i = 0; i < N; i++) begin
            if (feed_en && (feed_t_q >= (KW+1)'(i)) && ((feed_t_q - (KW+1)'(i)) < {1'b0, k_q})) begin
                lane_valid[i] = 1'b1;
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.start_err  = start_err_q;
    assign bus.array_clr  = (state_q == S_CLEAR) || !rst;
    assign bus.feed_en    = feed_en;
    assign bus.feed_t     = feed_t_q;
    assign bus.lane_valid = lane_valid;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_row    = res_row_q;
endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: job-level reference model compared every cycle, directed jobs with literal timing, random traffic.
module tb_systolic_ctrl;
    localparam int N  = 4;
    localparam int KW = 8;
    localparam int RW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    systolic_ctrl_if #(.N(N), .KW(KW), .RW(RW)) bus ();
    systolic_ctrl #(.N(N), .KW(KW), .RW(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Job model: cycles since the start was accepted plus result rows taken.
    bit m_active = 1'b0;
    bit m_err    = 1'b0;
    int m_cyc    = 0;
    int m_k      = 0;
    int m_rows   = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_active <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            m_err <= 1'b0;
            if (m_active) begin
                if (bus.abort || m_rows == N) begin
                    m_active <= 1'b0;
                end else begin
                    if (m_cyc >= m_k + 2*N && bus.res_ready) m_rows <= m_rows + 1;
                    m_cyc <= m_cyc + 1;
                end
            end else if (bus.start) begin
                if (bus.k_len != '0) begin
                    m_active <= 1'b1;
                    m_cyc    <= 1;
                    m_rows   <= 0;
                    m_k      <= int'(bus.k_len);
                end else begin
                    m_err <= 1'b1;
                end
            end
        end
    end

    bit           e_feed, e_read;
    int           e_t;
    logic [N-1:0] e_lane;

    always @(negedge clk) begin
        e_feed = m_active && m_cyc >= 2 && m_cyc <= m_k + 2*N - 1;
        e_read = m_active && m_cyc >= m_k + 2*N && m_rows < N;
        e_t    = m_cyc - 2;
        e_lane = '0;
        for (int i = 0; i < N; i++) begin
            if (e_feed && e_t >= i && e_t - i < m_k) e_lane[i] = 1'b1;
        end
        chk("busy", bus.busy, m_active);
        chk("done", bus.done, m_active && m_rows == N);
        chk("start_err", bus.start_err, m_err);
        chk("array_clr", bus.array_clr, !rst || (m_active && m_cyc == 1));
        chk("feed_en", bus.feed_en, e_feed);
        chk("lane_valid", bus.lane_valid, e_lane);
        chk("res_valid", bus.res_valid, e_read);
        if (e_feed) chk("feed_t", bus.feed_t, e_t);
        if (e_read) chk("res_row", bus.res_row, m_rows);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic launch(input int k);
        bus.start = 1'b1;
        bus.k_len = KW'(k);
        tick();
        bus.start = 1'b0;
    endtask

    // Runs one job from cycle 1; lo_* = res_ready low window, abort/poke/rst cycle numbers (0 = never).
    task automatic job(input string name, input int k, input int ncyc, input int lo_from, input int lo_to,
                       input int abort_n, input int poke_n, input int rst_n, input int exp_done);
        int done_at;
        bit err_seen;
        done_at  = -1;
        err_seen = 1'b0;
        launch(k);
        for (int n = 1; n <= ncyc; n++) begin
            if (bus.done && done_at < 0) done_at = n;
            if (bus.start_err) err_seen = 1'b1;
            if (rst_n != 0 && n == rst_n) chk({name, "_row_before_rst"}, bus.res_row, 2);
            if (rst_n != 0 && n == rst_n + 1) begin
                chk({name, "_rst_busy"}, bus.busy, 0);
                chk({name, "_rst_clr"}, bus.array_clr, 1);
                chk({name, "_rst_row"}, bus.res_row, 0);
            end
            if (lo_from != 0 && n == lo_to) chk({name, "_held_row"}, bus.res_row, 1);
            bus.res_ready = !(n >= lo_from && n <= lo_to);
            bus.abort     = (n == abort_n);
            bus.start     = (n == poke_n);
            if (n == poke_n) bus.k_len = '0;
            rst           = !(n == rst_n);
            tick();
        end
        rst           = 1'b1;
        bus.abort     = 1'b0;
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        chk({name, "_done_cycle"}, done_at, exp_done);
        chk({name, "_no_err"}, err_seen, 0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.k_len     = '0;
        bus.abort     = 1'b0;
        bus.res_ready = 1'b1;
        rst           = 1'b0;
        repeat (3) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_feed_t", bus.feed_t, 0);
        chk("rst_res_row", bus.res_row, 0);
        chk("rst_clr", bus.array_clr, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        rst = 1'b1;
        tick();

        // Nominal K=3 job with literal timing.
        launch(3);
        for (int n = 1; n <= 16; n++) begin
            if (n == 1) chk("nom_clr", bus.array_clr, 1);
            if (n == 2) begin
                chk("nom_t0", bus.feed_t, 0);
                chk("nom_lane_t0", bus.lane_valid, 4'b0001);
            end
            if (n == 5) chk("nom_lane_t3", bus.lane_valid, 4'b1110);
            if (n == 10) begin
                chk("nom_t8", bus.feed_t, 8);
                chk("nom_lane_t8", bus.lane_valid, 4'b0000);
            end
            if (n == 11) chk("nom_row0", {bus.res_valid, bus.res_row}, 3'b100);
            if (n == 14) chk("nom_row3", {bus.res_valid, bus.res_row}, 3'b111);
            if (n == 15) chk("nom_done", bus.done, 1);
            if (n == 16) chk("nom_idle", bus.busy, 0);
            if (n < 16) tick();
        end

        job("bp", 3, 18, 12, 13, 0, 0, 0, 17);

        bus.start = 1'b1;
        bus.k_len = '0;
        tick();
        bus.start = 1'b0;
        chk("zero_err", bus.start_err, 1);
        chk("zero_busy", bus.busy, 0);
        chk("zero_clr", bus.array_clr, 0);
        tick();
        chk("zero_err_once", bus.start_err, 0);

        job("abort", 3, 8, 0, -1, 6, 0, 0, -1);
        job("after_abort", 2, 16, 0, -1, 0, 0, 0, 14);
        job("rst_read", 3, 16, 0, -1, 0, 0, 13, -1);
        job("poke", 3, 17, 0, -1, 0, 4, 0, 15);

        for (int c = 0; c < 4000; c++) begin
            bus.start     = ($urandom_range(0, 5) == 0);
            bus.k_len     = KW'($urandom_range(0, 6));
            bus.res_ready = ($urandom_range(0, 3) != 0);
            bus.abort     = ($urandom_range(0, 80) == 0);
            rst           = ($urandom_range(0, 300) != 0);
            tick();
        end
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.res_ready = 1'b1;
        rst           = 1'b1;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencing controller for an N×N output-stationary systolic array built from `mac_unit` PEs. It runs one matrix-multiply job at a time:

- clears the PE accumulators;
- generates the skewed per-lane feed schedule that external data muxes use to drive the array's row (x) and column (w) edges;
- waits for the wavefront to drain;
- streams the N result rows out under a valid/ready handshake.

It owns no datapath. The array and the operand/result muxing sit outside it.

## Interface

- `N`, 4: array dimension, 2..64.
- `KW`, 8: width of the inner-dimension length `k_len`.
- `RW`, 2: width of `res_row`, equal to clog2(N).

Ports:

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  job request, sampled in IDLE only.
- `k_len`  in  KW  inner dimension K; sampled with `start`.
- `abort`  in  1  cancel current job.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse when a job completes normally.
- `start_err`  out  1  one-cycle pulse when `start` is rejected because `k_len`==0.
- `array_clr`  out  1  active-high clear to every PE `rst`.
- `feed_en`  out  1  high during FEED.
- `feed_t`  out  KW+1  feed cycle index t.
- `lane_valid`  out  N  bit i: lane i (row i x and column i w) carries element k = t−i this cycle. When the bit is 0, the lane's data must be 0.
- `res_valid`  out  1  result row presented.
- `res_ready`  in  1  consumer accepts the row.
- `res_row`  out  RW  index of the result row currently presented.

## Operation

- **States:** IDLE, CLEAR, FEED, READ, DONE.
- **IDLE:**
  - `start`=1 and `k_len`≠0 → latch K=`k_len`, go to CLEAR.
  - `start`=1 and `k_len`=0 → `start_err` pulses next cycle; stay in IDLE.
- **CLEAR:** one cycle with `array_clr`=1; t←0; go to FEED.
- **FEED:** lasts K+2N−2 cycles, t = 0..K+2N−3.
  - `lane_valid[i]` = (t ≥ i) and (t − i < K).
  - The trailing cycles, where all lanes are invalid, let the skewed operands propagate to PE(N−1,N−1).
  - At t = K+2N−3 → READ, with `res_row`←0.
- **READ:**
  - `res_valid`=1; `lane_valid`=0.
  - Each cycle with `res_valid` and `res_ready` both high increments `res_row`.
  - A handshake at `res_row`=N−1 → DONE.
  - PE sums stay stable because all array inputs are 0.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **`abort`:** any state other than IDLE → IDLE next cycle. No `done` pulse, `res_valid` drops, and no `array_clr` is issued; the next job's CLEAR handles clearing.
- **`start` while busy:** ignored, with no error pulse.
- **Arithmetic:** `feed_t` is an unsigned counter that never wraps. KW+1 bits hold K+2N−3 because 2N−3 ≤ 2^KW is required (guaranteed for N ≤ 64 and KW ≥ 7).
- **`lane_valid` compare:** computed on KW+1-bit values; t−i is evaluated only when t ≥ i.

## Timing

- State, counters, `busy`, `done`, `start_err`, `res_valid` and `res_row` are registered.
- `lane_valid` and `feed_en` are decoded from registered state and `feed_t`.
- `array_clr` = (state==CLEAR) OR (`rst`==0), so the array is cleared during controller reset.
- **Reset values** (`rst` low at an edge): state IDLE, and the following outputs are 0: `busy`, `done`, `start_err`, `feed_en`, `feed_t`, `lane_valid`, `res_valid`, `res_row`.
- **Reset mid-job:** same as above; takes priority over `abort` and `start`.
- **Latency** (`start` sampled at edge E0; cycle n is the cycle after edge E0+n−1):
  - CLEAR in cycle 1.
  - FEED in cycles 2..K+2N−1.
  - First `res_valid` in cycle K+2N.
  - With `res_ready` held at 1: READ occupies cycles K+2N..K+3N−1 and `done` is in cycle K+3N.
  - Each cycle of `res_ready`=0 during READ adds one cycle.
- `res_valid`/`res_row` must stay stable until accepted.
- A new `start` is accepted in the cycle after `done` at the earliest, i.e. in the first IDLE cycle.

## Test plan

- **Nominal job:** N=4, `start` with `k_len`=3, `res_ready`=1 → `array_clr` in cycle 1; FEED cycles 2..10 with `feed_t` 0..8; `lane_valid`=0001 at t=0, 1110 at t=3, 0000 at t=8; `res_row` 0,1,2,3 in cycles 11..14; `done` in cycle 15. With the array attached, the PE sums equal A·B.
- **Backpressure:** same job with `res_ready` low for 2 cycles while `res_row`=1 → `res_row` holds at 1 with `res_valid` high; `done` moves to cycle 17.
- **Zero-length start:** `start` with `k_len`=0 → `start_err` pulses once; `busy` stays 0; no `array_clr`.
- **Abort mid-FEED:** `abort` at t=4 → IDLE next cycle; `busy`=0, `lane_valid`=0, no `done`; a following job with K=2 completes normally with `done` in cycle K+3N = 14.
- **Reset mid-READ:** `rst` low while `res_row`=2 → all outputs at reset values, `array_clr`=1 while `rst` is low; after release, a `start` is accepted normally.
- **Start while busy:** `start` pulsed during FEED → ignored; job timing unchanged; no `start_err`.
